// File: rtl/i3c_pkg.sv
// Shared types and default sizing for the I3C shared-bus fabric.
package i3c_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_DRAIN
    } arb_state_e;

    localparam int DEF_N_AGENTS    = 6;
    localparam int DEF_N_CTRL      = 3;
    localparam int DEF_IDLE_CYCLES = 16;

    // Position of the lowest set bit; callers pass a one-hot vector.
    function automatic int onehot_idx(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

endpackage

// File: rtl/i3c_rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr, wrapping modulo N.
module i3c_rr_arbiter #(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i3c_bus_fabric.sv
// Shared SDA/SCL resolution, START/STOP detection, bus-free timing,
// arbitration-loss reporting and round-robin controller ownership.
module i3c_bus_fabric
    import i3c_pkg::*;
#(
    parameter int N_AGENTS    = DEF_N_AGENTS,
    parameter int N_CTRL      = DEF_N_CTRL,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_AGENTS-1:0] sda_od_low,
    input  logic [N_AGENTS-1:0] sda_pp_en,
    input  logic [N_AGENTS-1:0] sda_pp_val,
    input  logic [N_AGENTS-1:0] scl_od_low,
    input  logic [N_AGENTS-1:0] scl_pp_en,
    input  logic [N_AGENTS-1:0] scl_pp_val,
    input  logic [N_AGENTS-1:0] tx_active,
    output logic                sda,
    output logic                scl,
    output logic                start_det,
    output logic                stop_det,
    output logic                bus_busy,
    output logic                bus_free,
    output logic                pp_conflict,
    output logic [N_AGENTS-1:0] arb_lost,
    input  logic [N_CTRL-1:0]   mst_req,
    output logic [N_CTRL-1:0]   mst_grant
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam int PTR_W = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);

    // Wired-AND bus: open-drain low dominates, push-pull drivers AND together, else pull-up.
    function automatic logic resolve_line(input logic [N_AGENTS-1:0] od,
                                          input logic [N_AGENTS-1:0] en,
                                          input logic [N_AGENTS-1:0] val);
        if (|od) return 1'b0;
        if (|en) return &(val | ~en);
        return 1'b1;
    endfunction

    function automatic logic line_conflict(input logic [N_AGENTS-1:0] od,
                                           input logic [N_AGENTS-1:0] en,
                                           input logic [N_AGENTS-1:0] val);
        logic drv_hi;
        logic drv_lo;
        drv_hi = |(en & val);
        drv_lo = |(en & ~val);
        return (drv_hi && drv_lo) || (drv_hi && |od);
    endfunction

    logic             sda_d1;
    logic             scl_d1;
    logic [CNT_W-1:0] idle_cnt;
    arb_state_e       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [N_CTRL-1:0] win;
    logic             win_vld;
    logic             start_cond;
    logic             stop_cond;
    logic             scl_rise;
    logic [N_AGENTS-1:0] lose;

    assign start_cond = scl && scl_d1 && sda_d1 && !sda;
    assign stop_cond  = scl && scl_d1 && !sda_d1 && sda;
    assign scl_rise   = scl && !scl_d1;
    assign lose       = tx_active & ~sda_od_low & ~(sda_pp_en & ~sda_pp_val)
                      & {N_AGENTS{scl_rise && !sda}};
    assign bus_free   = (idle_cnt == CNT_MAX) && !bus_busy;

    i3c_rr_arbiter #(.N(N_CTRL)) u_arb (
        .req    (mst_req),
        .rr_ptr (rr_ptr),
        .grant  (win),
        .valid  (win_vld)
    );

    // Line resolution, condition detection and idle timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda         <= 1'b1;
            scl         <= 1'b1;
            sda_d1      <= 1'b1;
            scl_d1      <= 1'b1;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            bus_busy    <= 1'b0;
            pp_conflict <= 1'b0;
            arb_lost    <= '0;
            idle_cnt    <= '0;
        end else begin
            sda         <= resolve_line(sda_od_low, sda_pp_en, sda_pp_val);
            scl         <= resolve_line(scl_od_low, scl_pp_en, scl_pp_val);
            sda_d1      <= sda;
            scl_d1      <= scl;
            pp_conflict <= line_conflict(sda_od_low, sda_pp_en, sda_pp_val) ||
                           line_conflict(scl_od_low, scl_pp_en, scl_pp_val);
            start_det   <= start_cond;
            stop_det    <= stop_cond;
            arb_lost    <= lose;
            if (start_cond)     bus_busy <= 1'b1;
            else if (stop_cond) bus_busy <= 1'b0;
            if (!sda || !scl || bus_busy || start_det) idle_cnt <= '0;
            else if (idle_cnt != CNT_MAX)              idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Ownership FSM: a drop while the bus is busy must wait out STOP plus idle time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            mst_grant <= '0;
            rr_ptr    <= PTR_W'(N_CTRL - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus_free && win_vld) begin
                        mst_grant <= win;
                        rr_ptr    <= PTR_W'(onehot_idx(32'(win)));
                        state     <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if ((mst_req & mst_grant) == '0) begin
                        mst_grant <= '0;
                        state     <= bus_busy ? ARB_DRAIN : ARB_IDLE;
                    end
                end
                ARB_DRAIN: begin
                    mst_grant <= '0;
                    if (bus_free) state <= ARB_IDLE;
                end
                default: begin
                    mst_grant <= '0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
